// File: rtl/hasyncfifo_fwft_param_pkg.sv
// Shared helpers for the dual-clock FWFT FIFO: gray/binary conversion and synchroniser depth.
// Functions work on a 32-bit container; callers size-cast to their pointer width.
package hasyncfifo_fwft_param_pkg;

    localparam int SYNC_STAGES = 2;

    typedef logic [31:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/hasyncfifo_fwft_param_hsync_gray.sv
// Multi-flop synchroniser for a gray-coded pointer crossing into the clk domain.
// Latency: STAGES clk edges. No backpressure; samples every edge.
// Reset: rst asynchronous, active-high, clears all stages.
module hasyncfifo_fwft_param_hsync_gray #(
    parameter int W      = 5,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/hasyncfifo_fwft_param.sv
// Dual-clock FIFO (clkw -> clkr) with show-ahead read port; FIFO_RDCNT_EN adds rd_count.
// Latency: a write into an empty FIFO shows valid on the 3rd clkr edge; back-to-back pops at 1 word/clkr.
// Backpressure: writes while full_flag are dropped; re without valid is ignored.
module hasyncfifo_fwft_param
    import hasyncfifo_fwft_param_pkg::*;
#(
    parameter int DW       = 12,
    parameter int AW       = 4,
    parameter int AFULL_TH = 12
) (
    input  logic          clkr,
    input  logic          rst,
    input  logic          clkw,
    input  logic          we,
    input  logic [DW-1:0] di,
    output logic          full_flag,
    output logic          afull,
    input  logic          re,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic          empty_flag
`ifdef FIFO_RDCNT_EN
    ,
    output logic [AW:0]   rd_count
`endif
);

    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    logic [AW:0] wbin, wgray, wbin_next, wgray_next;
    logic [AW:0] rgray_sync, rbin_sync;
    logic [AW:0] rbin, rgray, rbin_next, wgray_sync;
    logic        wr_en, fetch, empty_int;

    // ---------------- write domain ----------------
    assign wr_en      = we && !full_flag;
    assign wbin_next  = wbin + {{AW{1'b0}}, wr_en};
    assign wgray_next = PW'(bin2gray(ptr_t'(wbin_next)));
    assign rbin_sync  = PW'(gray2bin(ptr_t'(rgray_sync)));

    always_ff @(posedge clkw or posedge rst) begin
        if (rst) begin
            wbin      <= '0;
            wgray     <= '0;
            full_flag <= 1'b0;
            afull     <= 1'b0;
        end else begin
            wbin      <= wbin_next;
            wgray     <= wgray_next;
            // Full when the write pointer is one lap ahead: top two gray bits inverted.
            full_flag <= (wgray_next == {~rgray_sync[AW:AW-1], rgray_sync[AW-2:0]});
            afull     <= ((wbin_next - rbin_sync) >= PW'(AFULL_TH));
        end
    end

    always_ff @(posedge clkw) begin
        if (wr_en) begin
            mem[wbin[AW-1:0]] <= di;
        end
    end

    hasyncfifo_fwft_param_hsync_gray #(.W(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
        .clk (clkr),
        .rst (rst),
        .d   (wgray),
        .q   (wgray_sync)
    );

    hasyncfifo_fwft_param_hsync_gray #(.W(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
        .clk (clkw),
        .rst (rst),
        .d   (rgray),
        .q   (rgray_sync)
    );

    // ---------------- read domain ----------------
    assign empty_int = (rgray == wgray_sync);
    // Refill the output register whenever it is free or being popped this cycle.
    assign fetch     = !empty_int && (re || !valid);
    assign rbin_next = rbin + {{AW{1'b0}}, fetch};

    always_ff @(posedge clkr or posedge rst) begin
        if (rst) begin
            rbin  <= '0;
            rgray <= '0;
            valid <= 1'b0;
            dout  <= '0;
        end else begin
            rbin  <= rbin_next;
            rgray <= PW'(bin2gray(ptr_t'(rbin_next)));
            if (fetch) begin
                dout  <= mem[rbin[AW-1:0]];
                valid <= 1'b1;
            end else if (re && valid) begin
                valid <= 1'b0;
            end
        end
    end

    assign empty_flag = ~valid;

`ifdef FIFO_RDCNT_EN
    logic [AW:0] wbin_sync;
    assign wbin_sync = PW'(gray2bin(ptr_t'(wgray_sync)));

    // Words still in storage plus the one held in dout.
    always_ff @(posedge clkr or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
        end else begin
            rd_count <= (wbin_sync - rbin) + {{AW{1'b0}}, valid};
        end
    end
`endif

endmodule
